// File: rtl/multi_enc.sv
// Multi-hot to sequential binary index encoder: latches a request vector and emits one set-bit index per handshake.
// Optional macro MULTI_ENC_COUNT_EN adds out_cnt, the number of bits still pending.
module multi_enc #(
    parameter int unsigned N         = 8,
    parameter int unsigned W         = 3,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         busy
`ifdef MULTI_ENC_COUNT_EN
    ,
    output logic [W:0]   out_cnt
`endif
);

    if (W != $clog2(N) || N < 2 || N > 64) begin : g_param_check
        $error("multi_enc: N must be 2..64 and W must equal clog2(N)");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [N-1:0]   pend;
    logic [N-1:0]   pend_d;
    logic [N-1:0]   sel;
    logic [W-1:0]   idx;
    logic           single;
    logic           active;

    // Priority pick of the bit to serve; the last match in the loop wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (MSB_FIRST) begin
                if (pend[i]) idx = W'(i);
            end else begin
                if (pend[N-1-i]) idx = W'(N-1-i);
            end
        end
        sel = N'(1) << idx;
    end

    assign single = (pend != '0) && ((pend & (pend - N'(1))) == '0);

    // Outputs are decoded from registered state; reset forces the idle view immediately.
    assign active    = (state == SCAN) && rst_n;
    assign out_valid = active;
    assign busy      = active;
    assign out_last  = active && single;
    assign out_idx   = active ? idx : '0;
    assign in_ready  = !rst_n || (state == IDLE) || (single && out_ready);

    always_comb begin
        state_d = state;
        pend_d  = pend;
        unique case (state)
            IDLE: begin
                if (in_valid && (in_vec != '0)) begin
                    pend_d  = in_vec;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (single) begin
                        // Final pop may reload directly to avoid an idle bubble.
                        if (in_valid && (in_vec != '0)) begin
                            pend_d = in_vec;
                        end else begin
                            pend_d  = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        pend_d = pend & ~sel;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            state <= state_d;
            pend  <= pend_d;
        end
    end

`ifdef MULTI_ENC_COUNT_EN
    logic [W:0] cnt;

    // Popcount of pending bits, including the one currently presented.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < int'(N); i++) begin
            cnt = cnt + (W+1)'(pend[i]);
        end
    end

    assign out_cnt = active ? cnt : '0;
`endif

endmodule

// File: tb/tb_multi_enc.sv
// Directed bench for multi_enc: an MSB-first instance plus an LSB-first instance (out_cnt checked when MULTI_ENC_COUNT_EN is set).
module tb_multi_enc;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       busy;

    logic       l_in_valid;
    logic       l_in_ready;
    logic [7:0] l_in_vec;
    logic       l_out_valid;
    logic       l_out_ready;
    logic [2:0] l_out_idx;
    logic       l_out_last;
    logic       l_busy;
`ifdef MULTI_ENC_COUNT_EN
    logic [3:0] out_cnt;
    logic [3:0] l_out_cnt;
`endif

    int tests_run;
    int tests_failed;

    multi_enc #(.N(8), .W(3), .MSB_FIRST(1'b1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
`ifdef MULTI_ENC_COUNT_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    multi_enc #(.N(8), .W(3), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (l_in_valid),
        .in_ready  (l_in_ready),
        .in_vec    (l_in_vec),
        .out_valid (l_out_valid),
        .out_ready (l_out_ready),
        .out_idx   (l_out_idx),
        .out_last  (l_out_last),
        .busy      (l_busy)
`ifdef MULTI_ENC_COUNT_EN
        ,
        .out_cnt   (l_out_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Expected bundle is {out_valid, out_last, busy, in_ready, out_idx}.
    task automatic test_reset();
        logic [6:0] got;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_vec   = 8'hFF;
        step();
        step();
        #1;
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b0001_000) begin
            tests_failed++;
            $display("FAIL reset_hold got %b required %b", got, 7'b0001_000);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b0001_000) begin
            tests_failed++;
            $display("FAIL reset_discard got %b required %b", got, 7'b0001_000);
        end
    endtask

    task automatic test_basic();
        logic [2:0] exp_idx [4];
        logic [6:0] got;
        logic [6:0] exp;
        exp_idx = '{3'd7, 3'd5, 3'd2, 3'd0};
        in_valid  = 1'b1;
        in_vec    = 8'b1010_0101;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            got = {out_valid, out_last, busy, in_ready, out_idx};
            exp = {1'b1, (k == 3), 1'b1, (k == 3), exp_idx[k]};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL basic[%0d] got %b required %b", k, got, exp);
            end
            step();
        end
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b0001_000) begin
            tests_failed++;
            $display("FAIL basic_idle got %b required %b", got, 7'b0001_000);
        end
    endtask

    task automatic test_stall();
        logic [2:0] exp_idx [4];
        logic [6:0] got;
        logic [6:0] exp;
        exp_idx = '{3'd7, 3'd5, 3'd2, 3'd0};
        in_valid  = 1'b1;
        in_vec    = 8'hA5;
        out_ready = 1'b1;
        step();
        // Offer a vector while stalled; it must be ignored.
        out_ready = 1'b0;
        in_vec    = 8'h01;
        for (int k = 0; k < 3; k++) begin
            #1;
            got = {out_valid, out_last, busy, in_ready, out_idx};
            tests_run++;
            if (got !== 7'b1010_111) begin
                tests_failed++;
                $display("FAIL stall[%0d] got %b required %b", k, got, 7'b1010_111);
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            got = {out_valid, out_last, busy, in_ready, out_idx};
            exp = {1'b1, (k == 3), 1'b1, (k == 3), exp_idx[k]};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL stall_release[%0d] got %b required %b", k, got, exp);
            end
            step();
        end
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b0001_000) begin
            tests_failed++;
            $display("FAIL stall_idle got %b required %b", got, 7'b0001_000);
        end
    endtask

    task automatic test_zero_vec();
        logic [6:0] got;
        in_valid = 1'b1;
        in_vec   = 8'h00;
        step();
        in_valid = 1'b0;
        #1;
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b0001_000) begin
            tests_failed++;
            $display("FAIL zero_vec got %b required %b", got, 7'b0001_000);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [6:0] got;
        in_valid  = 1'b1;
        in_vec    = 8'h10;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b1111_100) begin
            tests_failed++;
            $display("FAIL b2b_final got %b required %b", got, 7'b1111_100);
        end
        in_valid = 1'b1;
        in_vec   = 8'h03;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_in_ready got %b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        #1;
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b1010_001) begin
            tests_failed++;
            $display("FAIL b2b_idx1 got %b required %b", got, 7'b1010_001);
        end
        step();
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b1111_000) begin
            tests_failed++;
            $display("FAIL b2b_idx0 got %b required %b", got, 7'b1111_000);
        end
        step();
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b0001_000) begin
            tests_failed++;
            $display("FAIL b2b_idle got %b required %b", got, 7'b0001_000);
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] got;
        in_valid  = 1'b1;
        in_vec    = 8'hFF;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #1;
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b1010_101) begin
            tests_failed++;
            $display("FAIL mid_pre_reset got %b required %b", got, 7'b1010_101);
        end
        rst_n = 1'b0;
        #1;
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b0001_000) begin
            tests_failed++;
            $display("FAIL mid_in_reset got %b required %b", got, 7'b0001_000);
        end
        step();
        rst_n = 1'b1;
        #1;
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b0001_000) begin
            tests_failed++;
            $display("FAIL mid_after_reset got %b required %b", got, 7'b0001_000);
        end
        in_valid = 1'b1;
        in_vec   = 8'h01;
        step();
        in_valid = 1'b0;
        #1;
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b1111_000) begin
            tests_failed++;
            $display("FAIL mid_reaccept got %b required %b", got, 7'b1111_000);
        end
        step();
        got = {out_valid, out_last, busy, in_ready, out_idx};
        tests_run++;
        if (got !== 7'b0001_000) begin
            tests_failed++;
            $display("FAIL mid_idle got %b required %b", got, 7'b0001_000);
        end
    endtask

    task automatic test_lsb_first();
        logic [6:0] got;
        l_in_valid  = 1'b1;
        l_in_vec    = 8'h81;
        l_out_ready = 1'b1;
        step();
        l_in_valid = 1'b0;
        #1;
        got = {l_out_valid, l_out_last, l_busy, l_in_ready, l_out_idx};
        tests_run++;
        if (got !== 7'b1010_000) begin
            tests_failed++;
            $display("FAIL lsb_first got %b required %b", got, 7'b1010_000);
        end
`ifdef MULTI_ENC_COUNT_EN
        tests_run++;
        if (l_out_cnt !== 4'd2) begin
            tests_failed++;
            $display("FAIL lsb_cnt_first got %0d required 2", l_out_cnt);
        end
`endif
        step();
        got = {l_out_valid, l_out_last, l_busy, l_in_ready, l_out_idx};
        tests_run++;
        if (got !== 7'b1111_111) begin
            tests_failed++;
            $display("FAIL lsb_second got %b required %b", got, 7'b1111_111);
        end
`ifdef MULTI_ENC_COUNT_EN
        tests_run++;
        if (l_out_cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL lsb_cnt_second got %0d required 1", l_out_cnt);
        end
`endif
        step();
        got = {l_out_valid, l_out_last, l_busy, l_in_ready, l_out_idx};
        tests_run++;
        if (got !== 7'b0001_000) begin
            tests_failed++;
            $display("FAIL lsb_idle got %b required %b", got, 7'b0001_000);
        end
`ifdef MULTI_ENC_COUNT_EN
        tests_run++;
        if (l_out_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL lsb_cnt_idle got %0d required 0", l_out_cnt);
        end
        tests_run++;
        if (out_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL msb_cnt_idle got %0d required 0", out_cnt);
        end
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_vec       = 8'h00;
        out_ready    = 1'b1;
        l_in_valid   = 1'b0;
        l_in_vec     = 8'h00;
        l_out_ready  = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_zero_vec();
        test_back_to_back();
        test_mid_reset();
        test_lsb_first();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multi_enc.md
MULTI_ENC -- requirements
Module: multi_enc

Interface
REQ-001 Parameter N, default 8, request vector width; legal range 2..64.
REQ-002 Parameter W, default 3, index width; SHALL equal $clog2(N).
REQ-003 Parameter MSB_FIRST, default 1: 1 = highest set bit served first; 0 = lowest set bit served first.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous reset, active-low.
REQ-006 in_valid  input  1  request vector offered.
REQ-007 in_ready  output  1  block can accept a vector this cycle.
REQ-008 in_vec  input  N  multi-hot request vector.
REQ-009 out_valid  output  1  out_idx holds a valid encoded index.
REQ-010 out_ready  input  1  consumer accepts out_idx this cycle.
REQ-011 out_idx  output  W  binary index of the bit currently served.
REQ-012 out_last  output  1  current index is the final set bit of the latched vector.
REQ-013 busy  output  1  high while in SCAN.

Function
REQ-014 Two states SHALL exist: IDLE and SCAN; pending register pend[N-1:0] holds unserved bits.
REQ-015 IDLE: in_ready=1, out_valid=0, out_last=0, busy=0, out_idx=0.
REQ-016 IDLE, in_valid=1 and in_vec!=0: pend<=in_vec, next state SCAN.
REQ-017 IDLE, in_valid=1 and in_vec==0: vector accepted and discarded; no output; stay IDLE.
REQ-018 SCAN: out_valid=1, busy=1; out_idx = index of highest (MSB_FIRST=1) or lowest (MSB_FIRST=0) set bit of pend.
REQ-019 out_last SHALL be 1 exactly when pend has one bit set.
REQ-020 Latency: first out_valid SHALL assert the cycle after the accepting edge.
REQ-021 SCAN, out_valid and out_ready: the served bit SHALL be cleared from pend; the next index appears the following cycle.
REQ-022 SCAN, out_ready=0: pend, out_idx and out_last SHALL hold unchanged; out_valid stays 1.
REQ-023 in_ready in SCAN SHALL be 1 only when out_last=1 and out_ready=1 (combinational from out_ready).
REQ-024 Final pop with simultaneous accept of nonzero in_vec: pend<=in_vec, stay SCAN, no idle bubble.
REQ-025 Final pop with simultaneous accept of in_vec==0, or no in_valid: pend<=0, next state IDLE.
REQ-026 in_vec SHALL be ignored whenever in_ready=0.

Reset
REQ-027 rst_n=0 at a rising edge SHALL set state=IDLE, pend=0; in any state, including mid-SCAN.
REQ-028 While and after reset: out_valid=0, out_last=0, busy=0, out_idx=0, in_ready=1.
REQ-029 A vector offered while rst_n=0 SHALL be discarded.

Configuration
REQ-030 Macro MULTI_ENC_COUNT_EN defined: extra output out_cnt[W:0] = popcount of pend (bits remaining including the current one); 0 in IDLE and reset.
REQ-031 Macro undefined: out_cnt port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 N=8, MSB_FIRST=1, out_ready=1, accept 8'b1010_0101 -> out_idx 7,5,2,0 on four consecutive cycles, out_last only with 0, then IDLE.
REQ-033 Same vector, out_ready=0 for 3 cycles after first out_valid -> out_idx held at 7 with out_valid=1, then 5,2,0 on release.
REQ-034 IDLE, in_valid=1, in_vec=8'h00 -> out_valid stays 0, in_ready stays 1, busy stays 0.
REQ-035 During final pop of 8'h10, in_valid=1 with 8'h03 -> in_ready=1 that cycle; next cycles out_idx 1 then 0, no out_valid gap.
REQ-036 rst_n=0 for one edge after second pop of 8'hFF -> next cycle out_valid=0, in_ready=1; then 8'h01 accepted -> out_idx 0, out_last=1.
REQ-037 MSB_FIRST=0, MULTI_ENC_COUNT_EN defined, accept 8'h81 -> out_idx 0 then 7; out_cnt 2 then 1, then 0 in IDLE.
